// File: rtl/cluster_axi_tcdm_responder.sv
// AXI4 slave that turns one burst at a time into single-beat TCDM requests.
// Reads return R beats with last; each write burst ends with one B response.
module cluster_axi_tcdm_responder #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned TCDM_SIZE      = 32'h0002_0000,
  parameter int unsigned MEM_ADDR_WIDTH = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]     aw_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [7:0]                  aw_len_i,
  input  logic [2:0]                  aw_size_i,
  input  logic [1:0]                  aw_burst_i,
  input  logic                        aw_valid_i,
  output logic                        aw_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                        w_last_i,
  input  logic                        w_valid_i,
  output logic                        w_ready_o,
  output logic [AXI_ID_WIDTH-1:0]     b_id_o,
  output logic [1:0]                  b_resp_o,
  output logic [AXI_USER_WIDTH-1:0]   b_user_o,
  output logic                        b_valid_o,
  input  logic                        b_ready_i,
  input  logic [AXI_ID_WIDTH-1:0]     ar_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic [7:0]                  ar_len_i,
  input  logic [2:0]                  ar_size_i,
  input  logic [1:0]                  ar_burst_i,
  input  logic                        ar_valid_i,
  output logic                        ar_ready_o,
  output logic [AXI_ID_WIDTH-1:0]     r_id_o,
  output logic [AXI_DATA_WIDTH-1:0]   r_data_o,
  output logic [1:0]                  r_resp_o,
  output logic                        r_last_o,
  output logic [AXI_USER_WIDTH-1:0]   r_user_o,
  output logic                        r_valid_o,
  input  logic                        r_ready_i,
  output logic                        mem_req_o,
  output logic [MEM_ADDR_WIDTH-1:0]   mem_add_o,
  output logic                        mem_wen_o,
  output logic [AXI_DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0] mem_be_o,
  input  logic                        mem_gnt_i,
  input  logic                        mem_r_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0]   mem_r_rdata_i
);

  // state   | meaning
  // IDLE    | arbitrate AR/AW, latch burst on accept
  // RD_REQ  | read request held until grant
  // RD_WAIT | wait for read data (one cycle after grant)
  // RD_RESP | R beat held until r_ready
  // WR_DATA | forward W beats to memory (or drain on error)
  // WR_RESP | B response held until b_ready
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_DATA, WR_RESP} state_t;

  localparam int unsigned OFF_BITS = $clog2(AXI_DATA_WIDTH/8);
  localparam int unsigned EW       = AXI_ADDR_WIDTH + 16;
  localparam logic [1:0]  BURST_INCR = 2'b01;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  state_t                    state_q, state_d;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [AXI_ADDR_WIDTH-1:0] offset_q;
  logic [7:0]                len_q, cnt_q;
  logic [2:0]                size_q;
  logic [1:0]                burst_q;
  logic                      err_q;
  logic                      rr_rd_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;

  logic                      pick_rd, pick_wr;
  logic                      acc_rd, acc_wr, beat_adv, rd_cap, w_hs;
  logic [AXI_ADDR_WIDTH-1:0] acc_addr, acc_off;
  logic [7:0]                acc_len;
  logic [2:0]                acc_size;
  logic [1:0]                acc_burst;
  logic [EW-1:0]             acc_last_off;
  logic                      acc_err;
  logic                      last_beat;

  // Round-robin: the side accepted last loses the next tie.
  assign pick_rd = ar_valid_i && (!aw_valid_i || rr_rd_q);
  assign pick_wr = aw_valid_i && (!ar_valid_i || !rr_rd_q);

  assign acc_addr  = pick_rd ? ar_addr_i  : aw_addr_i;
  assign acc_len   = pick_rd ? ar_len_i   : aw_len_i;
  assign acc_size  = pick_rd ? ar_size_i  : aw_size_i;
  assign acc_burst = pick_rd ? ar_burst_i : aw_burst_i;
  assign acc_off   = acc_addr - base_addr_i;

  // Last-beat offset is computed wide so a long burst cannot wrap past the window check.
  always_comb begin
    acc_last_off = EW'(acc_off);
    if (acc_burst == BURST_INCR)
      acc_last_off = EW'(acc_off) + (EW'(acc_len) << acc_size);
  end

  assign acc_err = acc_burst[1]
                 || (acc_size > 3'(OFF_BITS))
                 || (acc_addr < base_addr_i)
                 || (acc_last_off >= EW'(TCDM_SIZE));

  assign last_beat = (cnt_q == len_q);

  always_comb begin
    state_d     = state_q;
    aw_ready_o  = 1'b0;
    ar_ready_o  = 1'b0;
    w_ready_o   = 1'b0;
    b_valid_o   = 1'b0;
    b_resp_o    = 2'b00;
    r_valid_o   = 1'b0;
    r_last_o    = 1'b0;
    r_resp_o    = 2'b00;
    mem_req_o   = 1'b0;
    mem_wen_o   = 1'b0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    acc_rd      = 1'b0;
    acc_wr      = 1'b0;
    beat_adv    = 1'b0;
    rd_cap      = 1'b0;
    w_hs        = 1'b0;
    case (state_q)
      IDLE: begin
        ar_ready_o = pick_rd && !rst_i;
        aw_ready_o = pick_wr && !rst_i;
        if (ar_ready_o) begin
          acc_rd  = 1'b1;
          state_d = acc_err ? RD_RESP : RD_REQ;
        end else if (aw_ready_o) begin
          acc_wr  = 1'b1;
          state_d = WR_DATA;
        end
      end
      RD_REQ: begin
        mem_req_o = 1'b1;
        mem_wen_o = 1'b1;
        if (mem_gnt_i) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_r_valid_i) begin
          rd_cap  = 1'b1;
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        r_valid_o = 1'b1;
        r_last_o  = last_beat;
        r_resp_o  = err_q ? RESP_SLVERR : 2'b00;
        if (r_ready_i) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            beat_adv = 1'b1;
            state_d  = err_q ? RD_RESP : RD_REQ;
          end
        end
      end
      WR_DATA: begin
        if (err_q) begin
          w_ready_o = 1'b1;
        end else begin
          mem_req_o   = w_valid_i;
          mem_be_o    = w_strb_i;
          mem_wdata_o = w_data_i;
          w_ready_o   = mem_gnt_i && w_valid_i;
        end
        w_hs = w_valid_i && w_ready_o;
        if (w_hs) begin
          if (last_beat || w_last_i) state_d = WR_RESP;
          else                       beat_adv = 1'b1;
        end
      end
      WR_RESP: begin
        b_valid_o = 1'b1;
        b_resp_o  = err_q ? RESP_SLVERR : 2'b00;
        if (b_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      id_q     <= '0;
      offset_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      err_q    <= 1'b0;
      rr_rd_q  <= 1'b1;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (acc_rd || acc_wr) begin
        id_q     <= acc_rd ? ar_id_i : aw_id_i;
        offset_q <= acc_off;
        len_q    <= acc_len;
        size_q   <= acc_size;
        burst_q  <= acc_burst;
        cnt_q    <= '0;
        err_q    <= acc_err;
        rdata_q  <= '0;
        rr_rd_q  <= acc_wr;
      end
      if (beat_adv) begin
        cnt_q <= cnt_q + 8'd1;
        if (burst_q == BURST_INCR)
          offset_q <= offset_q + (AXI_ADDR_WIDTH'(1) << size_q);
      end
      if (rd_cap) rdata_q <= mem_r_rdata_i;
      // A w_last that disagrees with the beat count marks the burst as failed.
      if (w_hs && (w_last_i != last_beat)) err_q <= 1'b1;
    end
  end

  assign mem_add_o = MEM_ADDR_WIDTH'(offset_q & ~AXI_ADDR_WIDTH'((1 << OFF_BITS) - 1));
  assign r_data_o  = rdata_q;
  assign r_id_o    = id_q;
  assign b_id_o    = id_q;
  assign r_user_o  = '0;
  assign b_user_o  = '0;

endmodule

// File: tb/tb_cluster_axi_tcdm_responder.sv
// Directed bench for cluster_axi_tcdm_responder with a small TCDM memory model.
// Expected values are hand-written constants.
module tb_cluster_axi_tcdm_responder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] base_addr_i = 32'h1000_0000;
  logic [5:0]  aw_id_i = '0;
  logic [31:0] aw_addr_i = '0;
  logic [7:0]  aw_len_i = '0;
  logic [2:0]  aw_size_i = '0;
  logic [1:0]  aw_burst_i = '0;
  logic        aw_valid_i = 1'b0;
  logic        aw_ready_o;
  logic [63:0] w_data_i = '0;
  logic [7:0]  w_strb_i = '0;
  logic        w_last_i = 1'b0;
  logic        w_valid_i = 1'b0;
  logic        w_ready_o;
  logic [5:0]  b_id_o;
  logic [1:0]  b_resp_o;
  logic [5:0]  b_user_o;
  logic        b_valid_o;
  logic        b_ready_i = 1'b0;
  logic [5:0]  ar_id_i = '0;
  logic [31:0] ar_addr_i = '0;
  logic [7:0]  ar_len_i = '0;
  logic [2:0]  ar_size_i = '0;
  logic [1:0]  ar_burst_i = '0;
  logic        ar_valid_i = 1'b0;
  logic        ar_ready_o;
  logic [5:0]  r_id_o;
  logic [63:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o;
  logic [5:0]  r_user_o;
  logic        r_valid_o;
  logic        r_ready_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_add_o;
  logic        mem_wen_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_be_o;
  logic        mem_gnt_i = 1'b1;
  logic        mem_r_valid_i = 1'b0;
  logic [63:0] mem_r_rdata_i = '0;

  always #5 clk_i = ~clk_i;

  cluster_axi_tcdm_responder dut (
    .clk_i(clk_i), .rst_i(rst_i), .base_addr_i(base_addr_i),
    .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i), .aw_size_i(aw_size_i),
    .aw_burst_i(aw_burst_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_last_i(w_last_i), .w_valid_i(w_valid_i),
    .w_ready_o(w_ready_o),
    .b_id_o(b_id_o), .b_resp_o(b_resp_o), .b_user_o(b_user_o), .b_valid_o(b_valid_o),
    .b_ready_i(b_ready_i),
    .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i), .ar_size_i(ar_size_i),
    .ar_burst_i(ar_burst_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
    .r_id_o(r_id_o), .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .r_user_o(r_user_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
    .mem_req_o(mem_req_o), .mem_add_o(mem_add_o), .mem_wen_o(mem_wen_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .mem_r_valid_i(mem_r_valid_i), .mem_r_rdata_i(mem_r_rdata_i)
  );

  logic [63:0] mem [0:16383];
  logic [31:0] wr_q[$];
  int          req_cyc = 0;
  logic        rd_hs = 1'b0;
  logic [13:0] rd_idx = '0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] wd [4];

  // Memory model: requests are observed mid-cycle; read data returns one cycle after grant.
  always @(negedge clk_i) begin
    rd_hs = 1'b0;
    if (!rst_i) begin
      if (mem_req_o) req_cyc++;
      if (mem_req_o && mem_gnt_i && !mem_wen_o) begin
        wr_q.push_back(mem_add_o);
        for (int b = 0; b < 8; b++)
          if (mem_be_o[b]) mem[mem_add_o[16:3]][8*b +: 8] = mem_wdata_o[8*b +: 8];
      end
      rd_hs  = mem_req_o && mem_gnt_i && mem_wen_o;
      rd_idx = mem_add_o[16:3];
    end
  end

  always @(posedge clk_i) begin
    #1;
    mem_r_valid_i = rd_hs;
    mem_r_rdata_i = rd_hs ? mem[rd_idx] : 64'h0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic aw_send(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int   t = 0;
    logic hs = 1'b0;
    aw_id_i = id; aw_addr_i = addr; aw_len_i = len; aw_size_i = size; aw_burst_i = burst;
    aw_valid_i = 1'b1;
    while (!hs && t < 50) begin
      @(negedge clk_i); hs = aw_ready_o;
      @(posedge clk_i); #1; t++;
    end
    aw_valid_i = 1'b0;
    if (!hs) check("aw_timeout", 64'(hs), 64'd1);
  endtask

  task automatic ar_send(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int   t = 0;
    logic hs = 1'b0;
    ar_id_i = id; ar_addr_i = addr; ar_len_i = len; ar_size_i = size; ar_burst_i = burst;
    ar_valid_i = 1'b1;
    while (!hs && t < 50) begin
      @(negedge clk_i); hs = ar_ready_o;
      @(posedge clk_i); #1; t++;
    end
    ar_valid_i = 1'b0;
    if (!hs) check("ar_timeout", 64'(hs), 64'd1);
  endtask

  task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last,
                        input string tag);
    int   t = 0;
    logic hs = 1'b0;
    w_data_i = data; w_strb_i = strb; w_last_i = last; w_valid_i = 1'b1;
    while (!hs && t < 50) begin
      @(negedge clk_i); hs = w_ready_o;
      @(posedge clk_i); #1; t++;
    end
    w_valid_i = 1'b0; w_last_i = 1'b0;
    if (!hs) check({tag, "_w_timeout"}, 64'(hs), 64'd1);
  endtask

  task automatic b_recv(input logic [5:0] id, input logic [1:0] resp, input string tag);
    int t = 0;
    b_ready_i = 1'b1;
    do begin @(negedge clk_i); t++; end while (!b_valid_o && t < 50);
    if (!b_valid_o) begin
      check({tag, "_b_timeout"}, 64'(b_valid_o), 64'd1);
    end else begin
      check({tag, "_bresp"}, 64'(b_resp_o), 64'(resp));
      check({tag, "_bid"}, 64'(b_id_o), 64'(id));
    end
    @(posedge clk_i); #1;
    b_ready_i = 1'b0;
  endtask

  task automatic r_recv(input logic [63:0] data, input logic last, input logic [1:0] resp,
                        input logic [5:0] id, input logic hold, input string tag);
    int t = 0;
    r_ready_i = 1'b0;
    do begin @(negedge clk_i); t++; end while (!r_valid_o && t < 50);
    if (!r_valid_o) begin
      check({tag, "_r_timeout"}, 64'(r_valid_o), 64'd1);
    end else begin
      if (hold) begin
        check({tag, "_pre_data"}, r_data_o, data);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check({tag, "_hold_valid"}, 64'(r_valid_o), 64'd1);
      end
      check({tag, "_data"}, r_data_o, data);
      check({tag, "_last"}, 64'(r_last_o), 64'(last));
      check({tag, "_resp"}, 64'(r_resp_o), 64'(resp));
      check({tag, "_id"}, 64'(r_id_o), 64'(id));
      r_ready_i = 1'b1;
    end
    @(posedge clk_i); #1;
    r_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    for (int i = 0; i < 16384; i++) mem[i] = 64'h0;
    mem[8] = 64'h1111_2222_3333_4444;
    wd[0] = 64'h0123_4567_89AB_CDEF;
    wd[1] = 64'hFEDC_BA98_7654_3210;
    wd[2] = 64'hDEAD_BEEF_0000_0001;
    wd[3] = 64'hCAFE_F00D_5555_AAAA;

    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_handshake", 64'({aw_ready_o, ar_ready_o, w_ready_o, b_valid_o, r_valid_o,
                                r_last_o, mem_req_o}), 64'd0);
    check("rst_data", r_data_o | 64'(mem_add_o) | mem_wdata_o, 64'd0);
    check("rst_id_resp", 64'({r_id_o, b_id_o, r_resp_o, b_resp_o, r_user_o, b_user_o}), 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Round-robin on simultaneous AR/AW: read, write, read
    ar_id_i = 6'd1; ar_addr_i = 32'h1000_0040; ar_len_i = 8'd0; ar_size_i = 3'd3; ar_burst_i = 2'b01;
    aw_id_i = 6'd2; aw_addr_i = 32'h1000_0048; aw_len_i = 8'd0; aw_size_i = 3'd3; aw_burst_i = 2'b01;
    ar_valid_i = 1'b1; aw_valid_i = 1'b1;
    @(negedge clk_i);
    check("rr1_ready", 64'({ar_ready_o, aw_ready_o}), 64'b10);
    @(posedge clk_i); #1;
    ar_valid_i = 1'b0;
    r_recv(64'h1111_2222_3333_4444, 1'b1, 2'b00, 6'd1, 1'b0, "rr1");
    ar_valid_i = 1'b1;
    @(negedge clk_i);
    check("rr2_ready", 64'({ar_ready_o, aw_ready_o}), 64'b01);
    @(posedge clk_i); #1;
    aw_valid_i = 1'b0;
    w_send(64'h4848_4848_4848_4848, 8'hFF, 1'b1, "rr2");
    b_recv(6'd2, 2'b00, "rr2");
    aw_valid_i = 1'b1;
    @(negedge clk_i);
    check("rr3_ready", 64'({ar_ready_o, aw_ready_o}), 64'b10);
    @(posedge clk_i); #1;
    ar_valid_i = 1'b0; aw_valid_i = 1'b0;
    r_recv(64'h1111_2222_3333_4444, 1'b1, 2'b00, 6'd1, 1'b0, "rr3");

    // INCR write, 4 beats from offset 0x10
    wr_q.delete();
    aw_send(6'd5, 32'h1000_0010, 8'd3, 3'd3, 2'b01);
    for (int k = 0; k < 4; k++) w_send(wd[k], 8'hFF, k == 3, "incr");
    b_recv(6'd5, 2'b00, "incr");
    check("incr_nwr", 64'(wr_q.size()), 64'd4);
    check("incr_a0", 64'(wr_q[0]), 64'h10);
    check("incr_a1", 64'(wr_q[1]), 64'h18);
    check("incr_a2", 64'(wr_q[2]), 64'h20);
    check("incr_a3", 64'(wr_q[3]), 64'h28);

    // INCR read of the same data, grant stalled at first, r_ready held low a cycle per beat
    mem_gnt_i = 1'b0;
    ar_send(6'd9, 32'h1000_0010, 8'd3, 3'd3, 2'b01);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      check("rd_stall_req", 64'({mem_req_o, mem_wen_o}), 64'b11);
      check("rd_stall_add", 64'(mem_add_o), 64'h10);
      @(posedge clk_i); #1;
    end
    mem_gnt_i = 1'b1;
    for (int k = 0; k < 4; k++) r_recv(wd[k], k == 3, 2'b00, 6'd9, 1'b1, "rd");

    // WRAP read: error beats, no memory traffic
    c0 = req_cyc;
    ar_send(6'd3, 32'h1000_0040, 8'd1, 3'd3, 2'b10);
    r_recv(64'h0, 1'b0, 2'b10, 6'd3, 1'b0, "wrap0");
    r_recv(64'h0, 1'b1, 2'b10, 6'd3, 1'b0, "wrap1");
    check("wrap_memreq", 64'(req_cyc - c0), 64'd0);

    // Write whose last beat lands exactly at TCDM_SIZE: drained, SLVERR
    c0 = req_cyc;
    aw_send(6'd4, 32'h1001_FFF8, 8'd1, 3'd3, 2'b01);
    w_send(64'h1, 8'hFF, 1'b0, "oob");
    w_send(64'h2, 8'hFF, 1'b1, "oob");
    b_recv(6'd4, 2'b10, "oob");
    check("oob_memreq", 64'(req_cyc - c0), 64'd0);

    // Last beat at TCDM_SIZE-8 is still in range
    wr_q.delete();
    aw_send(6'd6, 32'h1001_FFF0, 8'd1, 3'd3, 2'b01);
    w_send(64'h3, 8'hFF, 1'b0, "edge");
    w_send(64'h4, 8'hFF, 1'b1, "edge");
    b_recv(6'd6, 2'b00, "edge");
    check("edge_nwr", 64'(wr_q.size()), 64'd2);
    check("edge_a1", 64'(wr_q[1]), 64'h1FFF8);

    // Early w_last on beat 1 of a 4-beat burst
    wr_q.delete();
    aw_send(6'd7, 32'h1000_0200, 8'd3, 3'd3, 2'b01);
    w_send(64'h5, 8'hFF, 1'b0, "early");
    w_send(64'h6, 8'hFF, 1'b1, "early");
    b_recv(6'd7, 2'b10, "early");
    check("early_nwr", 64'(wr_q.size()), 64'd2);

    // FIXED write: three beats to one address
    wr_q.delete();
    aw_send(6'd8, 32'h1000_0100, 8'd2, 3'd3, 2'b00);
    for (int k = 0; k < 3; k++) w_send(wd[k], 8'hFF, k == 2, "fixed");
    b_recv(6'd8, 2'b00, "fixed");
    check("fixed_nwr", 64'(wr_q.size()), 64'd3);
    for (int k = 0; k < 3; k++) check("fixed_addr", 64'(wr_q[k]), 64'h100);

    // Reset during RD_WAIT, then a normal read
    ar_send(6'd10, 32'h1000_0010, 8'd0, 3'd3, 2'b01);
    @(negedge clk_i);
    check("rw_req", 64'(mem_req_o), 64'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    #1;
    check("rw_rst_ctl", 64'({r_valid_o, mem_req_o, b_valid_o, w_ready_o, ar_ready_o, aw_ready_o}),
          64'd0);
    check("rw_rst_data", r_data_o | 64'({r_id_o, r_resp_o}), 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    ar_send(6'd11, 32'h1000_0018, 8'd0, 3'd3, 2'b01);
    r_recv(wd[1], 1'b1, 2'b00, 6'd11, 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
